// File: rtl/game_sequencer_if.sv
// game_sequencer_if
//   Bundles every game_sequencer signal except clk/rst.
//   Parameter SCORE_W sets the width of the score buses and must match the
//   SCORE_W of the game_sequencer instance it is connected to.
//
//   Signalling: there are no valid/ready pairs on this block. Every input is
//   a one-cycle strobe (or a level sampled alongside a strobe) that the
//   sequencer consumes at the posedge where it is high; it is never
//   back-pressured and never needs to be held. Every output is a registered
//   level that changes only at a posedge.
//
//   master : the environment (drives buttons, ticks and hits).
//   slave  : the sequencer (drives state, timer, scores and flags).
interface game_sequencer_if #(
  parameter int SCORE_W = 8
);
  logic               tick_1hz;
  logic               btn_start;
  logic               btn_pause;
  logic               btn_difficulty_pulse;
  logic [1:0]         difficulty_level_input;
  logic               hit_pulse;
  logic [2:0]         state;
  logic               enable_mole_ctrl;
  logic [1:0]         difficulty_level;
  logic [1:0]         active_player;
  logic [3:0]         round_num;
  logic [5:0]         time_left;
  logic [SCORE_W-1:0] player_score;
  logic [SCORE_W-1:0] best_score;
  logic [1:0]         best_player;
  logic               game_over;

  modport master (
    output tick_1hz, btn_start, btn_pause, btn_difficulty_pulse,
           difficulty_level_input, hit_pulse,
    input  state, enable_mole_ctrl, difficulty_level, active_player,
           round_num, time_left, player_score, best_score, best_player,
           game_over
  );

  modport slave (
    input  tick_1hz, btn_start, btn_pause, btn_difficulty_pulse,
           difficulty_level_input, hit_pulse,
    output state, enable_mole_ctrl, difficulty_level, active_player,
           round_num, time_left, player_score, best_score, best_player,
           game_over
  );
endinterface

// File: rtl/game_sequencer.sv
// game_sequencer
//   Turn/round sequencer for a whack-a-mole style game: countdown, timed
//   play per player, cumulative per-player scores, best-score tracking and
//   game-over hold. The FSM state is visible on bus.state.
//
//   Ports:
//     clk  - sole clock
//     rst  - synchronous active-high reset (to IDLE, all outputs 0)
//     bus  - game_sequencer_if.slave: button/tick/hit strobes in;
//            state, time_left, round/player, scores, flags out
//
//   Optional feature: define GAME_SEQUENCER_PAUSE_EN to build the pause
//   toggle (PAUSED state). Without it btn_pause is ignored and PAUSED is
//   never entered.
//
//   Event priority in one cycle: btn_start > btn_pause > tick_1hz.
//   All outputs come straight from flops loaded with next-state values.
module game_sequencer #(
  parameter int COUNTDOWN_SEC = 5,
  parameter int GAME_SEC      = 30,
  parameter int N_PLAYERS     = 2,
  parameter int N_ROUNDS      = 3,
  parameter int SCORE_W       = 8
) (
  input logic              clk,
  input logic              rst,
  game_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_PLAYING   = 3'd2,
    S_PAUSED    = 3'd3,
    S_ROUND_END = 3'd4,
    S_GAME_OVER = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [5:0]         time_q, time_d;
  // Four slots regardless of N_PLAYERS so a 2-bit player index is always in
  // range; slots at or above N_PLAYERS stay zero.
  logic [SCORE_W-1:0] score_q [4];
  logic [SCORE_W-1:0] score_d [4];
  logic [3:0]         round_q, round_d;
  logic [1:0]         player_q, player_d;
  logic [SCORE_W-1:0] best_q, best_d;
  logic [1:0]         best_p_q, best_p_d;
  logic [1:0]         diff_q, diff_d;
  logic [SCORE_W-1:0] pscore_q;
  logic               en_q;
  logic               over_q;
  logic               tick_play;

`ifdef GAME_SEQUENCER_PAUSE_EN
  // A pause request in PLAYING wins over a coincident tick.
  assign tick_play = bus.tick_1hz & ~bus.btn_pause;
`else
  logic unused_pause;
  assign unused_pause = bus.btn_pause;
  assign tick_play    = bus.tick_1hz;
`endif

  always_comb begin
    state_d  = state_q;
    time_d   = time_q;
    score_d  = score_q;
    round_d  = round_q;
    player_d = player_q;
    best_d   = best_q;
    best_p_d = best_p_q;
    diff_d   = diff_q;

    if (bus.btn_difficulty_pulse &&
        (state_q == S_IDLE || state_q == S_GAME_OVER))
      diff_d = bus.difficulty_level_input;

    if (bus.btn_start) begin
      state_d  = S_COUNTDOWN;
      time_d   = 6'(COUNTDOWN_SEC);
      for (int i = 0; i < 4; i++) score_d[i] = '0;
      round_d  = '0;
      player_d = '0;
      best_d   = '0;
      best_p_d = '0;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_COUNTDOWN: begin
          if (bus.tick_1hz) begin
            if (time_q == 6'd1) begin
              state_d = S_PLAYING;
              time_d  = 6'(GAME_SEC);
            end else begin
              time_d = time_q - 6'd1;
            end
          end
        end
        S_PLAYING: begin
          // Hits are counted even on the expiring tick.
          if (bus.hit_pulse && (score_q[player_q] != '1))
            score_d[player_q] = score_q[player_q] + SCORE_W'(1);
`ifdef GAME_SEQUENCER_PAUSE_EN
          if (bus.btn_pause) state_d = S_PAUSED;
`endif
          if (tick_play) begin
            if (time_q == 6'd1) begin
              state_d = S_ROUND_END;
              time_d  = '0;
            end else begin
              time_d = time_q - 6'd1;
            end
          end
        end
`ifdef GAME_SEQUENCER_PAUSE_EN
        S_PAUSED: begin
          if (bus.btn_pause) state_d = S_PLAYING;
        end
`endif
        S_ROUND_END: begin
          // Strict '>' so a tie keeps the lower player index.
          best_d   = '0;
          best_p_d = '0;
          for (int i = 0; i < N_PLAYERS; i++) begin
            if (score_q[i] > best_d) begin
              best_d   = score_q[i];
              best_p_d = 2'(i);
            end
          end
          if (player_q < 2'(N_PLAYERS - 1)) begin
            player_d = player_q + 2'd1;
            state_d  = S_COUNTDOWN;
            time_d   = 6'(COUNTDOWN_SEC);
          end else if (round_q < 4'(N_ROUNDS - 1)) begin
            round_d  = round_q + 4'd1;
            player_d = '0;
            state_d  = S_COUNTDOWN;
            time_d   = 6'(COUNTDOWN_SEC);
          end else begin
            state_d = S_GAME_OVER;
          end
        end
        S_GAME_OVER: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      time_q   <= '0;
      for (int i = 0; i < 4; i++) score_q[i] <= '0;
      round_q  <= '0;
      player_q <= '0;
      best_q   <= '0;
      best_p_q <= '0;
      diff_q   <= '0;
      pscore_q <= '0;
      en_q     <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      time_q   <= time_d;
      score_q  <= score_d;
      round_q  <= round_d;
      player_q <= player_d;
      best_q   <= best_d;
      best_p_q <= best_p_d;
      diff_q   <= diff_d;
      pscore_q <= score_d[player_d];
      en_q     <= (state_d == S_PLAYING);
      over_q   <= (state_d == S_GAME_OVER);
    end
  end

  assign bus.state            = state_q;
  assign bus.time_left        = time_q;
  assign bus.round_num        = round_q;
  assign bus.active_player    = player_q;
  assign bus.player_score     = pscore_q;
  assign bus.best_score       = best_q;
  assign bus.best_player      = best_p_q;
  assign bus.difficulty_level = diff_q;
  assign bus.enable_mole_ctrl = en_q;
  assign bus.game_over        = over_q;

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter COUNTDOWN_SEC, default 5, countdown length in seconds (legal 1..63).
REQ-002 Parameter GAME_SEC, default 30, play time per turn in seconds (legal 1..63).
REQ-003 Parameter N_PLAYERS, default 2, players taking turns (legal 1..4).
REQ-004 Parameter N_ROUNDS, default 3, rounds per game (legal 1..15).
REQ-005 Parameter SCORE_W, default 8, score width in bits.
REQ-006 The module SHALL have these ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- tick_1hz  in  1  one-cycle pulse, once per second.
- btn_start  in  1  one-cycle pulse; start or full restart.
- btn_pause  in  1  one-cycle pulse; pause toggle.
- btn_difficulty_pulse  in  1  one-cycle pulse; latch difficulty.
- difficulty_level_input  in  2  requested difficulty.
- hit_pulse  in  1  one-cycle pulse; a valid mole hit.
- state  out  3  current state code.
- enable_mole_ctrl  out  1  high only in PLAYING.
- difficulty_level  out  2  latched difficulty.
- active_player  out  2  player whose turn it is.
- round_num  out  4  zero-based current round.
- time_left  out  6  remaining seconds in COUNTDOWN or PLAYING, otherwise 0.
- player_score  out  SCORE_W  score of active_player.
- best_score  out  SCORE_W  highest player score.
- best_player  out  2  index of the player holding best_score.
- game_over  out  1  high in GAME_OVER.

Function
REQ-007 State codes SHALL be IDLE=0, COUNTDOWN=1, PLAYING=2, PAUSED=3, ROUND_END=4, GAME_OVER=5; all outputs SHALL be registered.
REQ-008 btn_start in any state SHALL cause a full restart on the next cycle:
- go to COUNTDOWN;
- time_left=COUNTDOWN_SEC;
- all player scores, round_num, active_player, best_score and best_player = 0.
REQ-009 In COUNTDOWN, each tick_1hz SHALL decrement time_left; a tick with time_left==1 SHALL enter PLAYING with time_left=GAME_SEC.
REQ-010 In PLAYING, behaviour SHALL be:
- enable_mole_ctrl=1;
- each hit_pulse increments the active player's score, saturating at 2^SCORE_W-1;
- each tick decrements time_left;
- a tick with time_left==1 enters ROUND_END with time_left=0.
REQ-011 A hit_pulse coincident with the expiring tick SHALL still be counted.
REQ-012 ROUND_END SHALL last exactly one cycle, then branch:
- if active_player<N_PLAYERS-1: increment active_player, go to COUNTDOWN;
- else if round_num<N_ROUNDS-1: increment round_num, set active_player=0, go to COUNTDOWN;
- else go to GAME_OVER.
Every entry to COUNTDOWN SHALL load time_left=COUNTDOWN_SEC.
REQ-013 In the ROUND_END cycle, best_score/best_player SHALL be updated from all player scores (including the score just finished); the larger score wins and a tie keeps the lower index.
REQ-014 GAME_OVER SHALL hold all scores, round_num, active_player and best outputs, with game_over=1, until btn_start.
REQ-015 btn_difficulty_pulse SHALL latch difficulty_level_input into difficulty_level only in IDLE or GAME_OVER; it SHALL be ignored in all other states.
REQ-016 hit_pulse SHALL be ignored outside PLAYING; tick_1hz SHALL be ignored outside COUNTDOWN and PLAYING.
REQ-017 Priority on a simultaneous event SHALL be btn_start > btn_pause > tick_1hz.

Reset
REQ-018 While rst is high at a clk edge, the block SHALL enter IDLE and drive every output to 0, including difficulty_level=0 and all scores.
REQ-019 rst asserted mid-game SHALL abandon the game with no retained score; IDLE SHALL be left only on btn_start.

Configuration
REQ-020 Macro GAME_SEQUENCER_PAUSE_EN SHALL control the pause feature.
- Defined: btn_pause in PLAYING enters PAUSED. PAUSED keeps time_left and scores frozen, drives enable_mole_ctrl=0, and ignores tick and hit. btn_pause in PAUSED returns to PLAYING. btn_start in PAUSED performs the full restart.
- Undefined: btn_pause is ignored, PAUSED is unreachable, and no pause logic is synthesised.

Verification (defaults unless noted)
REQ-021 Bench SHALL cover:
- rst, btn_start, 5 ticks -> state 1 with time_left 5,4,3,2,1, then state 2 with time_left=30.
- Player 0 gets 7 hits, 30 ticks, ROUND_END -> active_player=1, state 1; player 1 gets 9 hits; across 3 rounds -> GAME_OVER, best_player=1, game_over=1.
- SCORE_W=4 with 20 hits -> player_score saturates at 15.
- Hit on the final tick -> counted; btn_start together with a tick in PLAYING -> state 1, time_left=5, scores 0.
- With GAME_SEQUENCER_PAUSE_EN: pause at time_left=12, 3 ticks and 2 hits -> time_left 12 and score unchanged; unpause -> countdown resumes. Without the macro: the pause pulse is ignored.
- Tie 5/5 -> best_player=0; difficulty pulse in PLAYING ignored, in GAME_OVER latched.
